// File: rtl/det_seq_ctrl_if.sv
// Bundles the request handshake and the determinant-datapath control/status signals.
// The master side is the requester plus datapath; the slave side is the sequencer.
interface det_seq_ctrl_if #(
  parameter int BATCH_W = 4
);
  logic               start;
  logic [3:0]         start_address;
  logic [BATCH_W-1:0] batch_len;
  logic               abort;
  logic [15:0]        dp_out;
  logic               dp_carry_out;
  logic               dp_rst;
  logic [3:0]         dp_start_address;
  logic               en_counter;
  logic               sel;
  logic               busy;
  logic [15:0]        result;
  logic               result_valid;
  logic               done;
  logic               seq_err;

  modport master (
    output start, start_address, batch_len, abort, dp_out, dp_carry_out,
    input  dp_rst, dp_start_address, en_counter, sel,
    input  busy, result, result_valid, done, seq_err
  );

  modport slave (
    input  start, start_address, batch_len, abort, dp_out, dp_carry_out,
    output dp_rst, dp_start_address, en_counter, sel,
    output busy, result, result_valid, done, seq_err
  );
endinterface

// File: rtl/det_seq_ctrl.sv
// Sequences the 2x2 determinant datapath over a batch of 4-word matrices; first result 9 cycles
// after start, +7 per extra matrix. No backpressure: start is ignored while busy, abort cancels.
module det_seq_ctrl #(
  parameter int BATCH_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  det_seq_ctrl_if.slave io
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    LOAD,
    MUL_AD,
    MUL_BC,
    CAPT
  } state_t;

  state_t             state;
  logic [1:0]         k;
  logic [BATCH_W-1:0] remaining;

  // The datapath must see reset the moment rst rises, so this path stays combinational.
  assign io.dp_rst = rst | (state == INIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      k                   <= 2'd0;
      remaining           <= '0;
      io.dp_start_address <= 4'd0;
      io.en_counter       <= 1'b0;
      io.sel              <= 1'b1;
      io.busy             <= 1'b0;
      io.result           <= 16'd0;
      io.result_valid     <= 1'b0;
      io.done             <= 1'b0;
      io.seq_err          <= 1'b0;
    end else begin
      io.result_valid <= 1'b0;
      io.done         <= 1'b0;

      // Carry must fire exactly on the fourth load beat.
      if (state == LOAD && (io.dp_carry_out != (k == 2'd3)))
        io.seq_err <= 1'b1;

      if (state != IDLE && io.abort) begin
        state         <= IDLE;
        io.en_counter <= 1'b0;
        io.sel        <= 1'b1;
        io.busy       <= 1'b0;
        if (state == CAPT)
          io.result <= io.dp_out;
      end else begin
        case (state)
          IDLE: begin
            if (io.start) begin
              if (io.batch_len != '0) begin
                io.dp_start_address <= io.start_address;
                remaining           <= io.batch_len;
                io.seq_err          <= 1'b0;
                io.busy             <= 1'b1;
                state               <= INIT;
              end else begin
                io.done <= 1'b1;
              end
            end
          end
          INIT: begin
            state         <= LOAD;
            k             <= 2'd0;
            io.en_counter <= 1'b1;
            io.sel        <= 1'b1;
          end
          LOAD: begin
            k <= k + 2'd1;
            if (k == 2'd3) begin
              state         <= MUL_AD;
              io.en_counter <= 1'b0;
              io.sel        <= 1'b0;
            end
          end
          MUL_AD: begin
            state  <= MUL_BC;
            io.sel <= 1'b1;
          end
          MUL_BC: begin
            state <= CAPT;
          end
          CAPT: begin
            io.result       <= io.dp_out;
            io.result_valid <= 1'b1;
            remaining       <= remaining - BATCH_W'(1);
            // Counters already point at the next matrix, so skip INIT.
            if (remaining > BATCH_W'(1)) begin
              state         <= LOAD;
              k             <= 2'd0;
              io.en_counter <= 1'b1;
            end else begin
              state   <= IDLE;
              io.done <= 1'b1;
              io.busy <= 1'b0;
            end
          end
          default: begin
            state         <= IDLE;
            io.en_counter <= 1'b0;
            io.sel        <= 1'b1;
            io.busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_det_seq_ctrl.sv
// Bench for det_seq_ctrl: behavioural datapath + memory, timing/result reference from batch arithmetic.
module tb_det_seq_ctrl;
  localparam int BATCH_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  det_seq_ctrl_if #(.BATCH_W(BATCH_W)) io ();
  det_seq_ctrl #(.BATCH_W(BATCH_W)) dut (.clk(clk), .rst(rst), .io(io.slave));

  // Datapath model: 4-word operand load, product registers, subtractor.
  logic [7:0]  mem [16];
  logic [1:0]  dcnt;
  logic [3:0]  daddr;
  logic [7:0]  dreg [4];
  logic [15:0] ad_r, bc_r;
  int          err_mode = 0;

  always @(posedge clk) begin
    if (io.dp_rst) begin
      dcnt  <= 2'd0;
      daddr <= io.dp_start_address;
    end else if (io.en_counter) begin
      dreg[dcnt] <= mem[daddr];
      dcnt       <= dcnt + 2'd1;
      daddr      <= daddr + 4'd1;
    end
    if (!io.sel) ad_r <= 16'(dreg[0]) * 16'(dreg[3]);
    else         bc_r <= 16'(dreg[1]) * 16'(dreg[2]);
  end

  assign io.dp_out       = ad_r - bc_r;
  assign io.dp_carry_out = (err_mode == 1) ? 1'b0 :
                           (io.en_counter && (dcnt == 2'd3 || (err_mode == 2 && dcnt == 2'd1)));

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [15:0] exp_result;
  logic        exp_seq;
  logic [3:0]  exp_dsa;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input int c, input logic e_rst, e_en, e_sel, e_busy, e_vld, e_done);
    chk($sformatf("dp_rst@%0d", c),       32'(io.dp_rst),           32'(e_rst));
    chk($sformatf("en_counter@%0d", c),   32'(io.en_counter),       32'(e_en));
    chk($sformatf("sel@%0d", c),          32'(io.sel),              32'(e_sel));
    chk($sformatf("busy@%0d", c),         32'(io.busy),             32'(e_busy));
    chk($sformatf("result_valid@%0d", c), 32'(io.result_valid),     32'(e_vld));
    chk($sformatf("done@%0d", c),         32'(io.done),             32'(e_done));
    chk($sformatf("result@%0d", c),       32'(io.result),           32'(exp_result));
    chk($sformatf("seq_err@%0d", c),      32'(io.seq_err),          32'(exp_seq));
    chk($sformatf("dp_start@%0d", c),     32'(io.dp_start_address), 32'(exp_dsa));
  endtask

  // One request: start in cycle 0, checks cycles 1..stop. ca>0 aborts in cycle ca.
  // Matrix i: load cycles 2+7i..5+7i, a*d select at 6+7i, result at 9+7i.
  task automatic run_req(input logic [3:0] sa, input int n, input int ca, input int emode,
                         input bit chained, input bit poke);
    logic [15:0] expv [16];
    int   last, stop, onset;
    logic e_rst, e_en, e_sel, e_busy, e_vld, e_done;
    bit   act;
    last  = (n == 0) ? 1 : 9 + 7 * (n - 1);
    stop  = (ca > 0) ? ca + 1 : last;
    onset = (emode == 2) ? 4 : 6;
    for (int i = 0; i < n; i++) begin
      int base, ma, mb, mc, md;
      base = (int'(sa) + 4 * i) % 16;
      ma = int'(mem[base]);
      mb = int'(mem[(base + 1) % 16]);
      mc = int'(mem[(base + 2) % 16]);
      md = int'(mem[(base + 3) % 16]);
      expv[i] = 16'(ma * md - mb * mc);
    end
    if (!chained) @(negedge clk);
    io.start         = 1'b1;
    io.start_address = sa;
    io.batch_len     = BATCH_W'(n);
    err_mode         = emode;
    for (int c = 1; c <= stop; c++) begin
      @(negedge clk);
      io.start = 1'b0;
      io.abort = 1'b0;
      act    = (ca == 0) || (c <= ca);
      e_rst  = act && n != 0 && c == 1;
      e_busy = act && n != 0 && c <= last - 1;
      e_done = act && c == last;
      e_en   = 1'b0;
      e_sel  = 1'b1;
      e_vld  = 1'b0;
      for (int i = 0; i < n; i++) begin
        int o;
        o = 2 + 7 * i;
        if (act && c >= o && c <= o + 3) e_en = 1'b1;
        if (act && c == o + 4) e_sel = 1'b0;
        if (c == o + 7) begin
          exp_result = expv[i];
          e_vld      = act;
        end
      end
      if (n != 0 && c == 1) begin
        exp_seq = 1'b0;
        exp_dsa = sa;
      end
      if (emode != 0 && n != 0 && c == onset) exp_seq = 1'b1;
      check_outs(c, e_rst, e_en, e_sel, e_busy, e_vld, e_done);
      if (c == ca) io.abort = 1'b1;
      if (poke && c == 3 && c < stop) begin
        io.start         = 1'b1;
        io.start_address = ~sa;
        io.batch_len     = BATCH_W'(n + 1);
      end
    end
    err_mode = 0;
  endtask

  task automatic rst_test();
    @(negedge clk);
    io.start         = 1'b1;
    io.start_address = 4'd9;
    io.batch_len     = BATCH_W'(2);
    @(negedge clk);
    io.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("en_before_rst", 32'(io.en_counter), 32'd1);
    rst = 1'b1;
    #1;
    exp_result = 16'd0;
    exp_seq    = 1'b0;
    exp_dsa    = 4'd0;
    check_outs(-1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outs(-2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    io.start         = 1'b0;
    io.abort         = 1'b0;
    io.start_address = 4'd0;
    io.batch_len     = '0;
    exp_result       = 16'd0;
    exp_seq          = 1'b0;
    exp_dsa          = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    repeat (2) @(negedge clk);
    check_outs(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Single positive result.
    mem[4] = 8'd3; mem[5] = 8'd2; mem[6] = 8'd1; mem[7] = 8'd5;
    run_req(4'd4, 1, 0, 0, 1'b0, 1'b0);
    chk("tp_positive", 32'(io.result), 32'h000D);

    // Negative result.
    mem[0] = 8'd1; mem[1] = 8'd4; mem[2] = 8'd4; mem[3] = 8'd2;
    run_req(4'd0, 1, 0, 0, 1'b0, 1'b0);
    chk("tp_negative", 32'(io.result), 32'hFFF2);

    // Two-matrix batch wrapping through address 15 -> 0.
    mem[12] = 8'd2; mem[13] = 8'd0; mem[14] = 8'd0; mem[15] = 8'd2;
    mem[0]  = 8'd5; mem[1]  = 8'd1; mem[2]  = 8'd2; mem[3]  = 8'd3;
    run_req(4'd12, 2, 0, 0, 1'b0, 1'b0);
    chk("tp_wrap", 32'(io.result), 32'h000D);

    // Abort in cycle 7, restart in cycle 8.
    run_req(4'd4, 1, 7, 0, 1'b0, 1'b0);
    chk("tp_abort_keep", 32'(io.result), 32'h000D);
    run_req(4'd8, 1, 0, 0, 1'b1, 1'b0);

    // Abort during the capture cycle still updates result.
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    run_req(4'd2, 2, 15, 0, 1'b0, 1'b0);

    // Handshake edges.
    run_req(4'd5, 2, 0, 0, 1'b0, 1'b1);
    run_req(4'd7, 0, 0, 0, 1'b0, 1'b0);
    run_req(4'd1, 1, 0, 0, 1'b0, 1'b0);
    run_req(4'd3, 1, 0, 0, 1'b1, 1'b0);
    run_req(4'd6, 0, 0, 0, 1'b1, 1'b0);

    // Carry faults, clear on next start, reset mid-load.
    run_req(4'd0, 1, 0, 1, 1'b0, 1'b0);
    run_req(4'd9, 0, 0, 0, 1'b0, 1'b0);
    run_req(4'd10, 1, 0, 0, 1'b0, 1'b0);
    run_req(4'd11, 2, 0, 2, 1'b0, 1'b0);
    rst_test();

    for (int r = 0; r < 40; r++) begin
      int n, ca, em;
      bit ch, pk;
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      n  = int'($urandom_range(0, 4));
      ca = 0;
      em = 0;
      if (n != 0 && $urandom_range(0, 3) == 0)
        ca = int'($urandom_range(1, 9 + 7 * (n - 1) - 1));
      else if (n != 0 && $urandom_range(0, 7) == 0)
        em = int'($urandom_range(1, 2));
      ch = ($urandom_range(0, 2) == 0);
      pk = ($urandom_range(0, 2) == 0);
      run_req(4'($urandom), n, ca, em, ch, pk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
